// File: rtl/flag_branch_resolver.sv
// flag_branch_resolver: consumes the ALU relational flags {not_equal, z, n},
// resolves conditional branch requests against them and hands taken /
// not-taken plus the next PC to the PC-update logic.
module flag_branch_resolver #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_valid,
    input  logic              not_equal,
    input  logic              z,
    input  logic              n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_take,
    output logic [ADDR_W-1:0] res_pc,
    output logic              res_timeout,
    output logic              flag_err
);

    // Wait counter only has to reach TIMEOUT-1; one bit when TIMEOUT is tiny or 0.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_reg,       state_next;
    logic [2:0]          flag_reg,        flag_next;      // {not_equal, z, n}
    logic                fresh_reg,       fresh_next;
    logic [CNT_W-1:0]    cnt_reg,         cnt_next;
    logic [2:0]          cond_reg,        cond_next;
    logic [ADDR_W-1:0]   target_reg,      target_next;
    logic [ADDR_W-1:0]   pc_reg,          pc_next;
    logic                res_valid_reg,   res_valid_next;
    logic                res_take_reg,    res_take_next;
    logic [ADDR_W-1:0]   res_pc_reg,      res_pc_next;
    logic                res_timeout_reg, res_timeout_next;
    logic                flag_err_reg,    flag_err_next;

    logic [2:0]          flag_in;
    logic                flag_bad;
    logic                accept;
    logic [2:0]          eval_flags;
    logic [7:0]          cond_hit;
    logic [2:0]          sel_cond;
    logic [ADDR_W-1:0]   sel_target;
    logic [ADDR_W-1:0]   sel_pc;
    logic [ADDR_W-1:0]   seq_pc;
    logic                take_eval;

    // Condition table over f = {not_equal, z, n}.
    function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] f);
        logic r;
        case (cond)
            3'd0:    r = f[1];              // EQ
            3'd1:    r = f[2];              // NE
            3'd2:    r = f[0];              // LT
            3'd3:    r = ~f[0];             // GE
            3'd4:    r = f[0] | f[1];       // LE
            3'd5:    r = ~f[0] & ~f[1];     // GT
            3'd6:    r = 1'b1;              // ALWAYS
            default: r = 1'b0;              // NEVER
        endcase
        return r;
    endfunction

    assign flag_in  = {not_equal, z, n};
    assign flag_bad = (not_equal == z) | (z & n);
    assign br_ready = rst_n & (state_reg == ST_IDLE);
    assign accept   = br_valid & br_ready;

    // Incoming flags always win over the stored copy.
    assign eval_flags = flag_valid ? flag_in : flag_reg;

    // Evaluate every condition code in parallel, then pick the requested one.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cond
            assign cond_hit[gi] = cond_eval(3'(gi), eval_flags);
        end
    endgenerate

    // In IDLE the request is still on the inputs; afterwards use the latched copy.
    assign sel_cond   = (state_reg == ST_IDLE) ? br_cond   : cond_reg;
    assign sel_target = (state_reg == ST_IDLE) ? br_target : target_reg;
    assign sel_pc     = (state_reg == ST_IDLE) ? pc        : pc_reg;
    assign seq_pc     = sel_pc + ADDR_W'(4);
    assign take_eval  = cond_hit[sel_cond];

    // Next-state, flag register and result computation.
    always_comb begin
        logic load_res;
        logic load_to;
        state_next       = state_reg;
        flag_next        = flag_reg;
        fresh_next       = fresh_reg;
        cnt_next         = cnt_reg;
        cond_next        = cond_reg;
        target_next      = target_reg;
        pc_next          = pc_reg;
        res_valid_next   = res_valid_reg;
        res_take_next    = res_take_reg;
        res_pc_next      = res_pc_reg;
        res_timeout_next = res_timeout_reg;
        flag_err_next    = flag_err_reg | (flag_valid & flag_bad);
        load_res         = 1'b0;
        load_to          = 1'b0;

        if (flush) begin
            state_next     = ST_IDLE;
            cnt_next       = '0;
            fresh_next     = 1'b0;
            res_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (flag_valid) begin
                        flag_next  = flag_in;
                        fresh_next = 1'b1;
                    end
                    if (accept) begin
                        cond_next   = br_cond;
                        target_next = br_target;
                        pc_next     = pc;
                        if (br_cond[2:1] == 2'b11) begin
                            // ALWAYS/NEVER never look at the flags
                            load_res = 1'b1;
                        end else if (fresh_reg && !flag_valid) begin
                            // Flags already waiting: resolve without a WAIT cycle
                            load_res   = 1'b1;
                            fresh_next = 1'b0;
                        end else begin
                            state_next = ST_WAIT;
                            cnt_next   = '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flag_valid) begin
                        load_res   = 1'b1;
                        fresh_next = 1'b0;
                    end else if (fresh_reg) begin
                        load_res   = 1'b1;
                        fresh_next = 1'b0;
                    end else if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
                        load_to = 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (flag_valid) begin
                        flag_next  = flag_in;
                        fresh_next = 1'b1;
                    end
                    if (res_ready) begin
                        state_next     = ST_IDLE;
                        res_valid_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            if (load_res) begin
                state_next       = ST_RESP;
                res_valid_next   = 1'b1;
                res_take_next    = take_eval;
                res_pc_next      = take_eval ? sel_target : seq_pc;
                res_timeout_next = 1'b0;
            end
            if (load_to) begin
                state_next       = ST_RESP;
                res_valid_next   = 1'b1;
                res_take_next    = 1'b0;
                res_pc_next      = seq_pc;
                res_timeout_next = 1'b1;
            end
        end
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            flag_reg        <= '0;
            fresh_reg       <= 1'b0;
            cnt_reg         <= '0;
            cond_reg        <= '0;
            target_reg      <= '0;
            pc_reg          <= '0;
            res_valid_reg   <= 1'b0;
            res_take_reg    <= 1'b0;
            res_pc_reg      <= '0;
            res_timeout_reg <= 1'b0;
            flag_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            flag_reg        <= flag_next;
            fresh_reg       <= fresh_next;
            cnt_reg         <= cnt_next;
            cond_reg        <= cond_next;
            target_reg      <= target_next;
            pc_reg          <= pc_next;
            res_valid_reg   <= res_valid_next;
            res_take_reg    <= res_take_next;
            res_pc_reg      <= res_pc_next;
            res_timeout_reg <= res_timeout_next;
            flag_err_reg    <= flag_err_next;
        end
    end

    assign res_valid   = res_valid_reg;
    assign res_take    = res_take_reg;
    assign res_pc      = res_pc_reg;
    assign res_timeout = res_timeout_reg;
    assign flag_err    = flag_err_reg;

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Bench for flag_branch_resolver: table of directed branches, hand-written
// corner sequences and randomized transactions checked against a
// transaction-level model of the flag register and branch rules.
module tb_flag_branch_resolver;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_valid, not_equal, z, n;
    logic        br_valid, br_ready;
    logic [2:0]  br_cond;
    logic [31:0] br_target, pc;
    logic        flush;
    logic        res_valid, res_ready, res_take, res_timeout, flag_err;
    logic [31:0] res_pc;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: last captured flags, fresh marker, sticky error.
    logic [2:0] m_flags;
    logic       m_fresh;
    logic       m_err;

    typedef struct {
        logic [2:0]  cond;
        logic [2:0]  f;
        logic [31:0] pc_v;
        logic [31:0] tgt;
        logic        take;
        logic [31:0] rpc;
    } vec_t;

    vec_t vt[12];

    flag_branch_resolver #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .flag_valid(flag_valid), .not_equal(not_equal), .z(z), .n(n),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_target(br_target), .pc(pc), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_take(res_take),
        .res_pc(res_pc), .res_timeout(res_timeout), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // Branch rule over f = {ne, z, n} written from the mnemonic table.
    function automatic logic spec_take(input logic [2:0] cond, input logic [2:0] f);
        logic ne, zz, nn;
        ne = f[2]; zz = f[1]; nn = f[0];
        case (cond)
            3'd0: return zz;
            3'd1: return ne;
            3'd2: return nn;
            3'd3: return !nn;
            3'd4: return nn || zz;
            3'd5: return !nn && !zz;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] pick_flags();
        int k;
        k = $urandom_range(0, 2);
        if (k == 0) return 3'b010;
        if (k == 1) return 3'b100;
        return 3'b101;
    endfunction

    task automatic drive_flags(input logic [2:0] f);
        flag_valid = 1'b1;
        not_equal  = f[2];
        z          = f[1];
        n          = f[0];
        if ((f[2] == f[1]) || (f[1] && f[0])) m_err = 1'b1;
    endtask

    // One complete branch transaction; entered and left at a negedge in IDLE.
    task automatic run_txn(input string tag, input logic [2:0] cond,
                           input logic [31:0] pc_v, input logic [31:0] tgt_v,
                           input bit pre, input logic [2:0] pre_f,
                           input bit c0, input logic [2:0] c0_f,
                           input int delay, input logic [2:0] late_f,
                           input int hold, input bit use_flush, input bit hold_strobe,
                           output logic got_take, output logic [31:0] got_pc);
        int          exp_lat, lat;
        logic        exp_take, exp_to;
        logic [31:0] exp_pc;
        logic [2:0]  hf;
        bit          late, got, stable;
        if (pre) begin
            drive_flags(pre_f);
            m_flags = pre_f;
            m_fresh = 1'b1;
            @(negedge clk);
            flag_valid = 1'b0;
        end
        chk($sformatf("%s/br_ready_idle", tag), br_ready, 1);
        br_valid  = 1'b1;
        br_cond   = cond;
        pc        = pc_v;
        br_target = tgt_v;
        if (c0) drive_flags(c0_f);
        exp_to = 1'b0;
        late   = 1'b0;
        if (cond[2:1] == 2'b11) begin
            exp_lat  = 1;
            exp_take = !cond[0];
            if (c0) begin m_flags = c0_f; m_fresh = 1'b1; end
        end else if (c0) begin
            m_flags  = c0_f;
            m_fresh  = 1'b0;
            exp_lat  = 2;
            exp_take = spec_take(cond, c0_f);
        end else if (m_fresh) begin
            m_fresh  = 1'b0;
            exp_lat  = 1;
            exp_take = spec_take(cond, m_flags);
        end else if (delay >= 1 && delay <= TIMEOUT) begin
            late     = 1'b1;
            exp_lat  = delay + 1;
            exp_take = spec_take(cond, late_f);
        end else begin
            exp_lat  = TIMEOUT + 1;
            exp_take = 1'b0;
            exp_to   = 1'b1;
        end
        exp_pc = exp_take ? tgt_v : pc_v + 32'd4;

        @(negedge clk);
        br_valid   = 1'b0;
        flag_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= TIMEOUT + 8 && !got; c++) begin
            if (res_valid === 1'b1) begin
                got = 1'b1;
                lat = c;
            end else begin
                if (late && c == delay) drive_flags(late_f);
                @(negedge clk);
                flag_valid = 1'b0;
            end
        end
        got_take = res_take;
        got_pc   = res_pc;
        chk($sformatf("%s/res_seen", tag), got, 1);
        chk($sformatf("%s/latency", tag), lat, exp_lat);
        chk($sformatf("%s/take", tag), res_take, exp_take);
        chk($sformatf("%s/res_pc", tag), res_pc, exp_pc);
        chk($sformatf("%s/timeout", tag), res_timeout, exp_to);
        chk($sformatf("%s/flag_err", tag), flag_err, m_err);

        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            if (hold_strobe && $urandom_range(0, 1) == 1) begin
                hf = pick_flags();
                drive_flags(hf);
                m_flags = hf;
                m_fresh = 1'b1;
            end
            @(negedge clk);
            flag_valid = 1'b0;
            if (!(res_valid === 1'b1 && res_take === exp_take && res_pc === exp_pc &&
                  res_timeout === exp_to && br_ready === 1'b0)) stable = 1'b0;
        end
        if (hold > 0) chk($sformatf("%s/hold_stable", tag), stable, 1);

        if (use_flush) begin
            flush   = 1'b1;
            m_fresh = 1'b0;
        end else begin
            res_ready = 1'b1;
        end
        @(negedge clk);
        flush     = 1'b0;
        res_ready = 1'b0;
        chk($sformatf("%s/res_drop", tag), res_valid, 0);
        chk($sformatf("%s/back_idle", tag), br_ready, 1);
        $display("txn %s cond=%0d pc=%08h tgt=%08h take=%0b res_pc=%08h lat=%0d to=%0b flush=%0b",
                 tag, cond, pc_v, tgt_v, exp_take, exp_pc, lat, exp_to, use_flush);
    endtask

    initial begin
        logic        t_take;
        logic [31:0] t_pc;

        vt[0]  = '{3'd0, 3'b010, 32'h0000_0040, 32'h0000_0100, 1'b1, 32'h0000_0100};
        vt[1]  = '{3'd1, 3'b010, 32'hFFFF_FFFC, 32'h0000_0200, 1'b0, 32'h0000_0000};
        vt[2]  = '{3'd6, 3'b100, 32'h0000_0020, 32'h0000_0030, 1'b1, 32'h0000_0030};
        vt[3]  = '{3'd7, 3'b010, 32'h0000_0020, 32'h0000_0030, 1'b0, 32'h0000_0024};
        vt[4]  = '{3'd2, 3'b101, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h0000_2000};
        vt[5]  = '{3'd3, 3'b101, 32'h0000_1000, 32'h0000_2000, 1'b0, 32'h0000_1004};
        vt[6]  = '{3'd4, 3'b010, 32'h0000_0010, 32'h0000_0080, 1'b1, 32'h0000_0080};
        vt[7]  = '{3'd5, 3'b100, 32'h0000_0010, 32'h0000_0080, 1'b1, 32'h0000_0080};
        vt[8]  = '{3'd5, 3'b010, 32'h0000_0010, 32'h0000_0080, 1'b0, 32'h0000_0014};
        vt[9]  = '{3'd3, 3'b100, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h0000_2000};
        vt[10] = '{3'd4, 3'b100, 32'h0000_0010, 32'h0000_0080, 1'b0, 32'h0000_0014};
        vt[11] = '{3'd1, 3'b100, 32'hFFFF_FFF0, 32'h0000_0008, 1'b1, 32'h0000_0008};

        rst_n = 1'b0;
        flag_valid = 1'b0; not_equal = 1'b0; z = 1'b0; n = 1'b0;
        br_valid = 1'b0; br_cond = 3'd0; br_target = '0; pc = '0;
        flush = 1'b0; res_ready = 1'b0;
        m_flags = '0; m_fresh = 1'b0; m_err = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset/outputs", {res_valid, res_take, res_pc, res_timeout, flag_err}, 0);
        chk("reset/br_ready", br_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset/br_ready", br_ready, 1);

        // Directed table with flags strobed just before each request
        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vt[i].cond, vt[i].pc_v, vt[i].tgt,
                    1'b1, vt[i].f, 1'b0, 3'b000, 0, 3'b000, 0, 1'b0, 1'b0, t_take, t_pc);
            chk($sformatf("vec%0d/tbl_take", i), t_take, vt[i].take);
            chk($sformatf("vec%0d/tbl_pc", i), t_pc, vt[i].rpc);
        end

        // LT with no fresh flags, flags arrive in the third WAIT cycle
        run_txn("lt_late", 3'd2, 32'h0000_0300, 32'h0000_0500, 1'b0, 3'b000,
                1'b0, 3'b000, 3, 3'b101, 0, 1'b0, 1'b0, t_take, t_pc);
        // GT with no flags at all: timeout
        run_txn("gt_timeout", 3'd5, 32'h0000_0700, 32'h0000_0900, 1'b0, 3'b000,
                1'b0, 3'b000, 0, 3'b000, 0, 1'b0, 1'b0, t_take, t_pc);
        // Flags on the last possible WAIT cycle still beat the timeout
        run_txn("edge_wait", 3'd1, 32'h0000_0A00, 32'h0000_0B00, 1'b0, 3'b000,
                1'b0, 3'b000, TIMEOUT, 3'b100, 0, 1'b0, 1'b0, t_take, t_pc);
        // Flags on the accept cycle are captured then consumed from WAIT
        run_txn("accept_flags", 3'd0, 32'h0000_0C00, 32'h0000_0D00, 1'b0, 3'b000,
                1'b1, 3'b010, 0, 3'b000, 0, 1'b0, 1'b0, t_take, t_pc);
        // Result held 5 cycles with res_ready low, then flushed
        run_txn("hold_flush", 3'd6, 32'h0000_0E00, 32'h0000_0F00, 1'b0, 3'b000,
                1'b0, 3'b000, 0, 3'b000, 5, 1'b1, 1'b0, t_take, t_pc);

        // Flush in IDLE discards fresh flags: next EQ must time out
        drive_flags(3'b010);
        m_flags = 3'b010;
        m_fresh = 1'b1;
        @(negedge clk);
        flag_valid = 1'b0;
        flush = 1'b1;
        m_fresh = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        run_txn("flush_fresh", 3'd0, 32'h0000_1100, 32'h0000_1200, 1'b0, 3'b000,
                1'b0, 3'b000, 0, 3'b000, 0, 1'b0, 1'b0, t_take, t_pc);

        // Flush while waiting returns to IDLE without a result
        br_valid = 1'b1; br_cond = 3'd2; pc = 32'h1300; br_target = 32'h1400;
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_wait/res_valid", res_valid, 0);
        chk("flush_wait/br_ready", br_ready, 1);

        // Randomized transactions
        for (int r = 0; r < 40; r++) begin
            logic [2:0]  rc;
            logic [31:0] rp;
            rc = 3'($urandom_range(0, 7));
            rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            run_txn($sformatf("rnd%0d", r), rc, rp, $urandom,
                    bit'($urandom_range(0, 1)), pick_flags(),
                    ($urandom_range(0, 3) == 0), pick_flags(),
                    $urandom_range(0, 17), pick_flags(),
                    $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'b1,
                    t_take, t_pc);
        end

        // Inconsistent flags set the sticky error; it survives a later transaction
        drive_flags(3'b110);
        m_flags = 3'b110;
        m_fresh = 1'b1;
        @(negedge clk);
        flag_valid = 1'b0;
        chk("flag_err/set", flag_err, 1);
        run_txn("err_sticky", 3'd0, 32'h0000_1500, 32'h0000_1600, 1'b0, 3'b000,
                1'b0, 3'b000, 0, 3'b000, 0, 1'b0, 1'b0, t_take, t_pc);

        // Asynchronous reset in the middle of WAIT
        br_valid = 1'b1; br_cond = 3'd2; pc = 32'h1700; br_target = 32'h1800;
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait/outputs", {res_valid, res_take, res_pc, res_timeout}, 0);
        chk("rst_wait/flag_err", flag_err, 0);
        chk("rst_wait/br_ready", br_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_flags = '0; m_fresh = 1'b0; m_err = 1'b0;
        @(negedge clk);
        chk("rst_wait/idle_after", br_ready, 1);
        run_txn("after_rst", 3'd3, 32'h0000_1900, 32'h0000_1A00, 1'b0, 3'b000,
                1'b0, 3'b000, 2, 3'b100, 0, 1'b0, 1'b0, t_take, t_pc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
